// File: rtl/rand_num.sv
// rand_num: free-running 16-bit maximal-length LFSR driving a 3-bit random value
// Ports: CLOCK_50 - system clock, rising edge
//        KEY[0]   - synchronous active-high reset, reloads the seed
//        LEDR     - current random value, lfsr[2:0] straight from the register
module rand_num #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       CLOCK_50,
    input  logic [0:0] KEY,
    output logic [2:0] LEDR
);
    // an all-zero seed would lock the LFSR, so it is substituted here
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    logic [15:0] lfsr;
    logic        fb;
    always_comb fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // the zero state cannot be left by shifting, so it reloads the seed like reset
    always_ff @(posedge CLOCK_50)
        lfsr <= (KEY[0] || lfsr == 16'h0000) ? INIT : {lfsr[14:0], fb};
    assign LEDR = lfsr[2:0];
endmodule

// File: tb/tb_rand_num.sv
// tb_rand_num: scoreboard bench for rand_num with hand-computed LFSR vectors
module tb_rand_num;
    logic       CLOCK_50 = 1'b0;
    logic [0:0] KEY = 1'b1;
    logic [2:0] LEDR;
    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    bit done = 1'b0;

    rand_num dut (.CLOCK_50(CLOCK_50), .KEY(KEY), .LEDR(LEDR));

    always #10 CLOCK_50 = ~CLOCK_50;

    // issue one cycle of stimulus; optionally expect lfsr after the coming edge
    task automatic cyc(input logic k, input logic chk, input logic [15:0] e);
        @(negedge CLOCK_50);
        KEY[0] = k;
        if (chk) exp_q.push_back(e);
    endtask

    // monitor: one expectation per edge, sampled 1 time unit after it
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dut.lfsr !== e) begin
                    failures++;
                    $display("FAIL lfsr got=%h want=%h t=%0t", dut.lfsr, e, $time);
                end
                checks++;
                if (LEDR !== e[2:0]) begin
                    failures++;
                    $display("FAIL ledr got=%b want=%b t=%0t", LEDR, e[2:0], $time);
                end
            end
        end
    end

    initial begin
        logic [15:0] seq[4];
        bit zero_seen, early_rep;
        seq[0] = 16'h59C3; seq[1] = 16'hB387; seq[2] = 16'h670F; seq[3] = 16'hCE1E;
        // KEY starts high: the first edge loads the seed
        exp_q.push_back(16'hACE1);
        cyc(1'b1, 1'b1, 16'hACE1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, seq[i]);
        // run on, then a one-cycle reset mid-sequence
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'hACE1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, seq[i]);
        // reset held for five edges
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 16'hACE1);
        cyc(1'b0, 1'b1, 16'h59C3);
        // lock-up guard: zero state on a non-reset edge reloads the seed
        @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        force dut.lfsr = 16'h0000;
        #1 release dut.lfsr;
        exp_q.push_back(16'hACE1);
        // period: reset, then 65535 shifts must first return to the seed
        cyc(1'b1, 1'b1, 16'hACE1);
        @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        zero_seen = 1'b0;
        early_rep = 1'b0;
        for (int i = 1; i <= 65535; i++) begin
            @(posedge CLOCK_50);
            #2;
            if (dut.lfsr == 16'h0000) zero_seen = 1'b1;
            if (i < 65535 && dut.lfsr == 16'hACE1) early_rep = 1'b1;
        end
        checks++;
        if (dut.lfsr !== 16'hACE1) begin
            failures++;
            $display("FAIL period_end got=%h want=%h", dut.lfsr, 16'hACE1);
        end
        checks++;
        if (zero_seen) begin
            failures++;
            $display("FAIL period_zero got=1 want=0");
        end
        checks++;
        if (early_rep) begin
            failures++;
            $display("FAIL period_repeat got=1 want=0");
        end
        @(negedge CLOCK_50);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d want=0", exp_q.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        if (!done) begin
            $display("FAIL timeout got=running want=finished");
            $fatal(1);
        end
    end
endmodule
